// File: rtl/match_controller.sv
// Best-of-N fight sequencer: divides CLK into game ticks, gates the game core to FIGHT,
// pulses round_rst on every COUNTDOWN entry and keeps round wins and the match winner.
module match_controller #(
    parameter int TICK_DIV        = 20000000,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 30,
    parameter int END_HOLD_TICKS  = 2,
    parameter int ROUNDS_TO_WIN   = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [1:0] p1_health,
    input  logic [1:0] p2_health,
    output logic       game_tick,
    output logic       round_rst,
    output logic [2:0] state,
    output logic [7:0] timer,
    output logic [1:0] round_num,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] winner
);
    // state      | meaning
    // S_IDLE     | waiting for start after reset
    // S_COUNT    | pre-round countdown, core frozen
    // S_FIGHT    | core steps on every tick, KO/timeout watched
    // S_END      | hold after a round, then next round or match over
    // S_OVER     | result shown until start
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_FIGHT = 3'd2;
    localparam logic [2:0] S_END   = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int         CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0] CD_LOAD  = 8'(COUNTDOWN_TICKS);
    localparam logic [7:0] RT_LOAD  = 8'(ROUND_TICKS);
    localparam logic [7:0] EH_LOAD  = 8'(END_HOLD_TICKS);
    localparam logic [1:0] RTW      = 2'(ROUNDS_TO_WIN);

    logic [CW-1:0] cnt, cnt_nxt;
    logic          tick_en, tick_nxt, last_tick, ko;
    logic [2:0]    state_nxt;
    logic [7:0]    timer_nxt;
    logic [1:0]    round_nxt, p1_nxt, p2_nxt, winner_nxt;
    logic          rst_nxt;

    assign tick_en   = (cnt == CNT_LAST);
    assign cnt_nxt   = tick_en ? '0 : cnt + CW'(1);
    assign tick_nxt  = (cnt_nxt == CNT_LAST);
    assign last_tick = tick_en && (timer == 8'd1);
    assign ko        = (p1_health == 2'd0) || (p2_health == 2'd0);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        round_nxt  = round_num;
        p1_nxt     = p1_rounds;
        p2_nxt     = p2_rounds;
        winner_nxt = winner;
        rst_nxt    = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_nxt  = S_COUNT;
                    timer_nxt  = CD_LOAD;
                    round_nxt  = 2'd1;
                    p1_nxt     = 2'd0;
                    p2_nxt     = 2'd0;
                    winner_nxt = 2'b00;
                    rst_nxt    = 1'b1;
                end
            end
            S_COUNT: begin
                if (last_tick) begin
                    state_nxt = S_FIGHT;
                    timer_nxt = RT_LOAD;
                end else if (tick_en) begin
                    timer_nxt = timer - 8'd1;
                end
            end
            S_FIGHT: begin
                // KO and timeout landing together collapse into one round end
                if (ko || last_tick) begin
                    state_nxt = S_END;
                    timer_nxt = EH_LOAD;
                    if (p1_health > p2_health) begin
                        if (p1_rounds != RTW) p1_nxt = p1_rounds + 2'd1;
                    end else if (p2_health > p1_health) begin
                        if (p2_rounds != RTW) p2_nxt = p2_rounds + 2'd1;
                    end
                end else if (tick_en) begin
                    timer_nxt = timer - 8'd1;
                end
            end
            S_END: begin
                if (last_tick) begin
                    if (p1_rounds == RTW) begin
                        state_nxt  = S_OVER;
                        timer_nxt  = 8'd0;
                        winner_nxt = 2'b01;
                    end else if (p2_rounds == RTW) begin
                        state_nxt  = S_OVER;
                        timer_nxt  = 8'd0;
                        winner_nxt = 2'b10;
                    end else if (round_num == 2'd3) begin
                        state_nxt = S_OVER;
                        timer_nxt = 8'd0;
                        if (p1_rounds > p2_rounds)      winner_nxt = 2'b01;
                        else if (p2_rounds > p1_rounds) winner_nxt = 2'b10;
                        else                            winner_nxt = 2'b11;
                    end else begin
                        state_nxt = S_COUNT;
                        timer_nxt = CD_LOAD;
                        round_nxt = round_num + 2'd1;
                        rst_nxt   = 1'b1;
                    end
                end else if (tick_en) begin
                    timer_nxt = timer - 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = 8'd0;
            end
        endcase
    end

    // game_tick is registered one cycle early so it lines up with tick_en in FIGHT
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            state     <= S_IDLE;
            timer     <= 8'd0;
            round_num <= 2'd0;
            p1_rounds <= 2'd0;
            p2_rounds <= 2'd0;
            winner    <= 2'b00;
            round_rst <= 1'b0;
            game_tick <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            state     <= state_nxt;
            timer     <= timer_nxt;
            round_num <= round_nxt;
            p1_rounds <= p1_nxt;
            p2_rounds <= p2_nxt;
            winner    <= winner_nxt;
            round_rst <= rst_nxt;
            game_tick <= tick_nxt && (state_nxt == S_FIGHT);
        end
    end
endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: randomized health/start stimulus compared every cycle
// against a tick-counting match model, plus fixed result checks per scenario.
module tb_match_controller;
    localparam int TD  = 4;
    localparam int CD  = 2;
    localparam int RT  = 5;
    localparam int EH  = 1;
    localparam int RTW = 2;

    localparam int IDLE = 0, CDN = 1, FIGHT = 2, REND = 3, OVER = 4;
    localparam int M_P1KO = 0, M_TO = 1, M_DKO = 2, M_RAND = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       start = 1'b0;
    logic [1:0] p1_health = 2'd3;
    logic [1:0] p2_health = 2'd3;
    logic       game_tick, round_rst;
    logic [2:0] state;
    logic [7:0] timer;
    logic [1:0] round_num, p1_rounds, p2_rounds, winner;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state, m_timer, m_round, m_r1, m_r2, m_win, k;
    bit m_gt, m_rr;

    match_controller #(
        .TICK_DIV(TD), .COUNTDOWN_TICKS(CD), .ROUND_TICKS(RT),
        .END_HOLD_TICKS(EH), .ROUNDS_TO_WIN(RTW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_tick(game_tick), .round_rst(round_rst), .state(state), .timer(timer),
        .round_num(round_num), .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .winner(winner)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_state = IDLE; m_timer = 0; m_round = 0; m_r1 = 0; m_r2 = 0; m_win = 0;
        m_gt = 1'b0; m_rr = 1'b0; k = 0;
    endtask

    // k counts CLK edges since reset release; a tick occurs in every TD-th cycle
    task automatic model_edge(bit st, int h1, int h2);
        bit tick;
        tick = (k % TD) == (TD - 1);
        m_rr = 1'b0;
        case (m_state)
            IDLE, OVER: if (st) begin
                m_state = CDN; m_timer = CD; m_round = 1;
                m_r1 = 0; m_r2 = 0; m_win = 0; m_rr = 1'b1;
            end
            CDN: if (tick) begin
                m_timer--;
                if (m_timer == 0) begin m_state = FIGHT; m_timer = RT; end
            end
            FIGHT: begin
                if (h1 == 0 || h2 == 0 || (tick && m_timer == 1)) begin
                    if (h1 > h2)      m_r1 = (m_r1 + 1 > RTW) ? RTW : m_r1 + 1;
                    else if (h2 > h1) m_r2 = (m_r2 + 1 > RTW) ? RTW : m_r2 + 1;
                    m_state = REND; m_timer = EH;
                end else if (tick) begin
                    m_timer--;
                end
            end
            REND: if (tick) begin
                m_timer--;
                if (m_timer == 0) begin
                    if (m_r1 == RTW || m_r2 == RTW || m_round == 3) begin
                        m_state = OVER; m_timer = 0;
                        m_win = (m_r1 > m_r2) ? 1 : (m_r2 > m_r1) ? 2 : 3;
                    end else begin
                        m_state = CDN; m_timer = CD; m_round++; m_rr = 1'b1;
                    end
                end
            end
            default: m_state = IDLE;
        endcase
        k++;
        m_gt = ((k % TD) == (TD - 1)) && (m_state == FIGHT);
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state",     8'(state),     8'(m_state));
        check("timer",     timer,         8'(m_timer));
        check("round_num", 8'(round_num), 8'(m_round));
        check("p1_rounds", 8'(p1_rounds), 8'(m_r1));
        check("p2_rounds", 8'(p2_rounds), 8'(m_r2));
        check("winner",    8'(winner),    8'(m_win));
        check("game_tick", 8'(game_tick), 8'(m_gt));
        check("round_rst", 8'(round_rst), 8'(m_rr));
    endtask

    // called in the low phase; drives inputs, takes one edge, checks, returns at negedge
    task automatic step(bit st, int h1, int h2);
        start = st; p1_health = 2'(h1); p2_health = 2'(h2);
        @(posedge CLK);
        model_edge(st, h1, h2);
        #1 check_all();
        @(negedge CLK);
    endtask

    task automatic run_until(int target, int mode, bit allow_start, int h1f, int h2f);
        int budget;
        int fc;
        bit st;
        int h1, h2;
        budget = 600;
        fc = 0;
        do begin
            if (m_state == FIGHT) fc++; else fc = 0;
            st = (m_state == IDLE || m_state == OVER) ? allow_start : 1'($urandom_range(0, 1));
            h1 = $urandom_range(0, 3);
            h2 = $urandom_range(0, 3);
            if (m_state == FIGHT) begin
                case (mode)
                    M_P1KO: begin
                        h1 = $urandom_range(1, 3);
                        h2 = (fc > 3) ? 0 : $urandom_range(1, 3);
                    end
                    M_TO:  begin h1 = h1f; h2 = h2f; end
                    M_DKO: begin h1 = 0; h2 = 0; end
                    default: begin
                        h1 = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 3);
                        h2 = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 3);
                    end
                endcase
            end
            step(st, h1, h2);
            budget--;
        end while (m_state != target && budget > 0);
        n_checks++;
        assert (m_state == target) else begin
            n_fail++;
            $error("FAIL run_until: reached state %0d expected %0d", m_state, target);
        end
    endtask

    initial begin
        model_reset();
        #1 RST_N = 1'b0;
        #1 check_all();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();

        repeat (5) step(1'b0, $urandom_range(0, 3), $urandom_range(0, 3));

        // P1 takes two rounds by KO, then a restart clears the result
        run_until(FIGHT, M_P1KO, 1'b1, 0, 0);
        check("fight_timer", timer, 8'(RT));
        run_until(OVER, M_P1KO, 1'b0, 0, 0);
        check("ko_winner", 8'(winner), 8'd1);
        check("ko_p1_rounds", 8'(p1_rounds), 8'd2);

        // timeout 2v1 awards P1, timeout 2v2 and double KO award nobody
        run_until(FIGHT, M_TO, 1'b1, 2, 1);
        check("restart_p1_rounds", 8'(p1_rounds), 8'd0);
        check("restart_winner", 8'(winner), 8'd0);
        run_until(REND, M_TO, 1'b0, 2, 1);
        check("to_award_p1", 8'(p1_rounds), 8'd1);
        check("to_hold_timer", timer, 8'(EH));
        run_until(FIGHT, M_TO, 1'b0, 2, 2);
        run_until(REND, M_TO, 1'b0, 2, 2);
        check("to_draw_p1", 8'(p1_rounds), 8'd1);
        check("to_draw_p2", 8'(p2_rounds), 8'd0);
        run_until(FIGHT, M_DKO, 1'b0, 0, 0);
        run_until(REND, M_DKO, 1'b0, 0, 0);
        check("dko_p1", 8'(p1_rounds), 8'd1);
        check("dko_p2", 8'(p2_rounds), 8'd0);
        run_until(OVER, M_RAND, 1'b0, 0, 0);
        check("r3_winner", 8'(winner), 8'd1);
        check("r3_round", 8'(round_num), 8'd3);

        // three drawn rounds
        run_until(OVER, M_TO, 1'b1, 2, 2);
        check("draw_winner", 8'(winner), 8'd3);
        check("draw_round", 8'(round_num), 8'd3);
        check("over_timer", timer, 8'd0);

        for (int i = 0; i < 6; i++) run_until(OVER, M_RAND, 1'b1, 0, 0);

        // start is ignored mid-fight; async reset clears everything at once
        run_until(FIGHT, M_TO, 1'b1, 3, 3);
        repeat (3) step(1'b1, 3, 3);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        model_reset();
        #1 check_all();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) step(1'b0, 3, 3);
        run_until(OVER, M_RAND, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
